core_seq: RTL and testbench

Parametrised successor to the core control sequencer. It owns the instruction pointer, branch/call/return control, an internal return-address stack, segment registers and vectored interrupt entry/exit. It sits between the instruction store (which supplies `cmd` for the current `IP`) and the datapath units, which decode the remaining opcodes from the same command word. It adds several features the previous core lacked:
- stall handling for every opcode;
- an internal stack with overflow/underflow fault;
- vectored interrupts with nesting guard;
- a HALT state.

---
 rtl/core_seq_pkg.sv | 43 ++++
 rtl/core_seq_ret_stack.sv | 38 +++
 rtl/core_seq.sv | 143 ++++++++++++++
 tb/tb_core_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared definitions for the core control sequencer: opcodes, command-word
// field accessors and the sequencer state encoding.
package core_seq_pkg;

  // Accessors take a zero-extended command word so they work for any DW <= MAX_DW.
  localparam int MAX_DW = 64;
  localparam int CW_MAX = MAX_DW + 14;

  localparam logic [5:0] OP_NOP     = 6'h00;
  localparam logic [5:0] OP_JMP     = 6'h10;
  localparam logic [5:0] OP_BREQ    = 6'h11;
  localparam logic [5:0] OP_BRNE    = 6'h12;
  localparam logic [5:0] OP_BRCS    = 6'h13;
  localparam logic [5:0] OP_BRCC    = 6'h14;
  localparam logic [5:0] OP_CALL    = 6'h15;
  localparam logic [5:0] OP_RET     = 6'h16;
  localparam logic [5:0] OP_RETI    = 6'h17;
  localparam logic [5:0] OP_EI      = 6'h18;
  localparam logic [5:0] OP_DI      = 6'h19;
  localparam logic [5:0] OP_SEG_SET = 6'h1A;
  localparam logic [5:0] OP_SEG_GET = 6'h1B;
  localparam logic [5:0] OP_HALT    = 6'h1F;

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  function automatic logic [5:0] cmd_opc(input logic [CW_MAX-1:0] c, input int dw);
    return c[dw+8 +: 6];
  endfunction

  function automatic logic [3:0] cmd_oper1(input logic [CW_MAX-1:0] c, input int dw);
    return c[dw+4 +: 4];
  endfunction

  function automatic logic [3:0] cmd_oper2(input logic [CW_MAX-1:0] c, input int dw);
    return c[dw +: 4];
  endfunction

  // Upper bits above dw carry the other fields; callers keep only [dw-1:0].
  function automatic logic [MAX_DW-1:0] cmd_data(input logic [CW_MAX-1:0] c);
    return c[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/core_seq_ret_stack.sv
// Return-address LIFO. Guards its own pointer against over/underflow but
// reports nothing; the sequencer owns fault policy.
module ret_stack #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  localparam int LW   = $clog2(DEPTH)
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [LW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [LW-1:0] top_idx;

  assign full    = (level == (LW+1)'(DEPTH));
  assign empty   = (level == '0);
  // When full the low bits wrap to 0, so top_idx still lands on DEPTH-1.
  assign top_idx = level[LW-1:0] - LW'(1);
  assign dout    = mem[top_idx];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)              level <= '0;
    else if (push && !full)   level <= level + (LW+1)'(1);
    else if (pop && !empty)   level <= level - (LW+1)'(1);
  end

  always_ff @(posedge gclk) begin
    if (push && !full) mem[level[LW-1:0]] <= din;
  end

endmodule

// File: rtl/core_seq.sv
// Core control sequencer: instruction pointer, branch/call/return, return
// stack, segment registers and vectored interrupt entry/exit.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int DW       = 16,
  parameter int RS_DEPTH = 8,
  parameter int N_SEG    = 4,
  parameter int SEG_W    = 8,
  parameter int N_INT    = 16,
  parameter int INT_BASE = 'h0010,
  localparam int IW      = $clog2(N_INT),
  localparam int LW      = $clog2(RS_DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [13+DW:0]   cmd,
  input  logic             cmd_valid,
  input  logic             mem_busy,
  input  logic             fl_zf,
  input  logic             fl_cf,
  input  logic             int_req,
  input  logic [IW-1:0]    int_num,
  output logic [DW-1:0]    IP,
  output logic             int_ack,
  output logic [SEG_W-1:0] seg_out,
  output logic             seg_valid,
  output logic [LW:0]      rs_level,
  output logic             fault,
  output logic             halted
);

  localparam int SI = (N_SEG > 1) ? $clog2(N_SEG) : 1;

  logic [CW_MAX-1:0] cmd_x;
  logic [5:0]        opc;
  logic [3:0]        oper1, oper2;
  logic [MAX_DW-1:0] data_x;
  logic [DW-1:0]     data;

  assign cmd_x  = CW_MAX'(cmd);
  assign opc    = cmd_opc(cmd_x, DW);
  assign oper1  = cmd_oper1(cmd_x, DW);
  assign oper2  = cmd_oper2(cmd_x, DW);
  assign data_x = cmd_data(cmd_x);
  assign data   = data_x[DW-1:0];

  // oper2 and the upper data bits are decoded by the datapath units.
  logic unused_fields;
  assign unused_fields = ^{oper2, data_x};

  state_t           state;
  logic             ie, in_isr;
  logic [SEG_W-1:0] seg [N_SEG];

  logic          slot, int_go, exec, is_call, is_pop, err, push, pop;
  logic          full, empty, seg_ok;
  logic [DW-1:0] ip_inc, rs_top, rs_din;
  logic [SI-1:0] seg_idx;

  assign ip_inc  = IP + DW'(1);
  assign slot    = (state == RUN) && cmd_valid && !mem_busy;
  assign int_go  = int_req && ie && !in_isr && !mem_busy &&
                   ((state == RUN) || (state == HALT));
  // An accepted interrupt discards the current command.
  assign exec    = slot && !int_go;
  assign is_call = (opc == OP_CALL);
  assign is_pop  = (opc == OP_RET) || (opc == OP_RETI);
  assign err     = (int_go && full) || (exec && is_call && full) ||
                   (exec && is_pop && empty);
  assign push    = !err && (int_go || (exec && is_call));
  assign pop     = !err && exec && is_pop;
  assign rs_din  = int_go ? IP : ip_inc;
  assign seg_ok  = (int'(oper1) < N_SEG);
  assign seg_idx = oper1[SI-1:0];

  ret_stack #(.DW(DW), .DEPTH(RS_DEPTH)) u_rs (
    .gclk  (CLK),
    .grst_n(RESET),
    .push  (push),
    .pop   (pop),
    .din   (rs_din),
    .dout  (rs_top),
    .level (rs_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      IP        <= '0;
      state     <= RUN;
      ie        <= 1'b0;
      in_isr    <= 1'b0;
      seg_out   <= '0;
      seg_valid <= 1'b0;
      int_ack   <= 1'b0;
      for (int i = 0; i < N_SEG; i++) seg[i] <= '0;
    end else begin
      seg_valid <= 1'b0;
      int_ack   <= 1'b0;
      if (err) begin
        state <= FAULT;
      end else if (int_go) begin
        IP      <= DW'(INT_BASE) + DW'(int_num);
        in_isr  <= 1'b1;
        int_ack <= 1'b1;
        state   <= RUN;
      end else if (exec) begin
        IP <= ip_inc;
        case (opc)
          OP_JMP:  IP <= data;
          OP_BREQ: if (fl_zf)  IP <= data;
          OP_BRNE: if (!fl_zf) IP <= data;
          OP_BRCS: if (fl_cf)  IP <= data;
          OP_BRCC: if (!fl_cf) IP <= data;
          OP_CALL: IP <= data;
          OP_RET:  IP <= rs_top;
          OP_RETI: begin
            IP     <= rs_top;
            in_isr <= 1'b0;
          end
          OP_EI:   ie <= 1'b1;
          OP_DI:   ie <= 1'b0;
          OP_SEG_SET: if (seg_ok) seg[seg_idx] <= data[SEG_W-1:0];
          OP_SEG_GET: if (seg_ok) begin
            seg_out   <= seg[seg_idx];
            seg_valid <= 1'b1;
          end
          OP_HALT: begin
            IP    <= IP;
            state <= HALT;
          end
          default: ;
        endcase
      end
    end
  end

  assign fault  = (state == FAULT);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a vector table driven through a
// scoreboard queue, plus hand-built stack-fault and async-reset sequences.
module tb_core_seq;
  import core_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [29:0] cmd;
  logic        cmd_valid, mem_busy, fl_zf, fl_cf, int_req;
  logic [3:0]  int_num;
  logic [15:0] IP;
  logic        int_ack, seg_valid, fault, halted;
  logic [7:0]  seg_out;
  logic [3:0]  rs_level;

  always #5 CLK = ~CLK;

  core_seq #(.DW(16), .RS_DEPTH(8), .N_SEG(4), .SEG_W(8), .N_INT(16), .INT_BASE('h10)) dut (
    .CLK(CLK), .RESET(RESET), .cmd(cmd), .cmd_valid(cmd_valid), .mem_busy(mem_busy),
    .fl_zf(fl_zf), .fl_cf(fl_cf), .int_req(int_req), .int_num(int_num), .IP(IP),
    .int_ack(int_ack), .seg_out(seg_out), .seg_valid(seg_valid), .rs_level(rs_level),
    .fault(fault), .halted(halted)
  );

  typedef struct {
    logic [15:0] ip;
    logic        ack, segv;
    logic [7:0]  seg;
    logic [3:0]  lvl;
    logic        flt, hlt;
  } exp_t;

  typedef struct {
    logic [5:0]  opc;
    logic [3:0]  o1;
    logic [15:0] d;
    logic        zf, cf, v, busy, irq;
    logic [3:0]  inum;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic [5:0] opc, input logic [3:0] o1, input logic [15:0] d,
                              input logic zf, input logic cf, input logic v, input logic busy,
                              input logic irq, input logic [3:0] inum, input logic [15:0] ip,
                              input logic ack, input logic segv, input logic [7:0] seg,
                              input logic [3:0] lvl, input logic flt, input logic hlt);
    vec_t r;
    r.opc = opc; r.o1 = o1; r.d = d; r.zf = zf; r.cf = cf; r.v = v; r.busy = busy;
    r.irq = irq; r.inum = inum;
    r.e.ip = ip; r.e.ack = ack; r.e.segv = segv; r.e.seg = seg; r.e.lvl = lvl;
    r.e.flt = flt; r.e.hlt = hlt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " ip"},        32'(IP),        32'(e.ip));
    chk({tag, " int_ack"},   32'(int_ack),   32'(e.ack));
    chk({tag, " seg_valid"}, 32'(seg_valid), 32'(e.segv));
    chk({tag, " seg_out"},   32'(seg_out),   32'(e.seg));
    chk({tag, " rs_level"},  32'(rs_level),  32'(e.lvl));
    chk({tag, " fault"},     32'(fault),     32'(e.flt));
    chk({tag, " halted"},    32'(halted),    32'(e.hlt));
  endtask

  task automatic apply(input vec_t v, input string tag);
    cmd       = {v.opc, v.o1, 4'h0, v.d};
    cmd_valid = v.v;
    mem_busy  = v.busy;
    fl_zf     = v.zf;
    fl_cf     = v.cf;
    int_req   = v.irq;
    int_num   = v.inum;
    sb.push_back(v.e);
    @(posedge CLK);
    #1;
    check_out(tag);
  endtask

  initial begin
    cmd = '0; cmd_valid = 0; mem_busy = 0; fl_zf = 0; fl_cf = 0; int_req = 0; int_num = 0;

    //        opc         o1  data      zf cf v bz irq n   IP       ak sv seg    lv f h
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,0,0, 16'h1,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,0,0, 16'h2,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,0,0, 16'h3,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,1,0,0, 16'h3,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,1,0,0, 16'h3,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_BREQ,    0, 16'h40,   1,0,1,0,0,0, 16'h40,   0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_BRCC,    0, 16'h80,   0,1,1,0,0,0, 16'h41,   0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_BRNE,    0, 16'h50,   1,0,1,0,0,0, 16'h42,   0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_BRCS,    0, 16'h50,   0,1,1,0,0,0, 16'h50,   0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_JMP,     0, 16'h5,    0,0,1,0,0,0, 16'h5,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_CALL,    0, 16'h20,   0,0,1,0,0,0, 16'h20,   0,0,8'h00, 1,0,0));
    tbl.push_back(mk(OP_RET,     0, 16'h0,    0,0,1,0,0,0, 16'h6,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_CALL,    0, 16'h30,   0,0,1,1,0,0, 16'h6,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_JMP,     0, 16'h99,   0,0,0,0,0,0, 16'h6,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_SEG_SET, 2, 16'hAB,   0,0,1,0,0,0, 16'h7,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_SEG_SET, 5, 16'hCD,   0,0,1,0,0,0, 16'h8,    0,0,8'h00, 0,0,0));
    tbl.push_back(mk(OP_SEG_GET, 2, 16'h0,    0,0,1,0,0,0, 16'h9,    0,1,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_EI,      0, 16'h0,    0,0,1,0,0,0, 16'hA,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_JMP,     0, 16'h9,    0,0,1,0,0,0, 16'h9,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,1,3, 16'h13,   1,0,8'hAB, 1,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,1,5, 16'h14,   0,0,8'hAB, 1,0,0));
    tbl.push_back(mk(OP_RETI,    0, 16'h0,    0,0,1,0,0,0, 16'h9,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_SEG_GET, 2, 16'h0,    0,0,1,0,0,0, 16'hA,    0,1,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,1,1,7, 16'hA,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,0,0,1,7, 16'h17,   1,0,8'hAB, 1,0,0));
    tbl.push_back(mk(OP_RETI,    0, 16'h0,    0,0,1,0,0,0, 16'hA,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_HALT,    0, 16'h0,    0,0,1,0,0,0, 16'hA,    0,0,8'hAB, 0,0,1));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,0,0, 16'hA,    0,0,8'hAB, 0,0,1));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,1,2, 16'h12,   1,0,8'hAB, 1,0,0));
    tbl.push_back(mk(OP_RETI,    0, 16'h0,    0,0,1,0,0,0, 16'hA,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_DI,      0, 16'h0,    0,0,1,0,0,0, 16'hB,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,1,1, 16'hC,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_JMP,     0, 16'hFFFF, 0,0,1,0,0,0, 16'hFFFF, 0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_NOP,     0, 16'h0,    0,0,1,0,0,0, 16'h0,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_BREQ,    0, 16'h70,   0,0,1,0,0,0, 16'h1,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_SEG_GET, 5, 16'h0,    0,0,1,0,0,0, 16'h2,    0,0,8'hAB, 0,0,0));
    tbl.push_back(mk(OP_SEG_GET, 0, 16'h0,    0,0,1,0,0,0, 16'h3,    0,1,8'h00, 0,0,0));

    // Reset state, held across a couple of edges.
    repeat (2) @(posedge CLK);
    #1;
    chk("reset ip",       32'(IP),        32'h0);
    chk("reset rs_level", 32'(rs_level),  32'h0);
    chk("reset seg_out",  32'(seg_out),   32'h0);
    chk("reset seg_valid",32'(seg_valid), 32'h0);
    chk("reset int_ack",  32'(int_ack),   32'h0);
    chk("reset fault",    32'(fault),     32'h0);
    chk("reset halted",   32'(halted),    32'h0);
    RESET = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Eight nested calls fill the stack; the ninth faults and freezes IP.
    for (int i = 0; i < 8; i++)
      apply(mk(OP_CALL, 0, 16'(16'h100 + i), 0,0,1,0,0,0, 16'(16'h100 + i),
               0,0,8'h00, 4'(i + 1), 0,0), $sformatf("call%0d", i));
    apply(mk(OP_CALL, 0, 16'h200, 0,0,1,0,0,0, 16'h107, 0,0,8'h00, 4'd8, 1,0), "call_ovf");
    apply(mk(OP_JMP,  0, 16'h0,   0,0,1,0,0,0, 16'h107, 0,0,8'h00, 4'd8, 1,0), "fault_frozen");

    // Asynchronous reset between edges.
    RESET = 1'b0;
    #1;
    chk("async ip",       32'(IP),       32'h0);
    chk("async rs_level", 32'(rs_level), 32'h0);
    chk("async fault",    32'(fault),    32'h0);
    chk("async seg_out",  32'(seg_out),  32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    apply(mk(OP_RET, 0, 16'h0,  0,0,1,0,0,0, 16'h0, 0,0,8'h00, 0, 1,0), "ret_empty");
    apply(mk(OP_JMP, 0, 16'h55, 0,0,1,0,0,0, 16'h0, 0,0,8'h00, 0, 1,0), "ret_frozen");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
